// File: rtl/bitcounter_4_pkg.sv
// Shared constants for the free-running tick/sequence counters.
package bitcounter_4_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage : bitcounter_4_pkg

// File: rtl/bitcounter_4.sv
// Free-running up-counter, modulo MAX_COUNT+1, with terminal-count decode
// and a registered one-cycle pulse after each wrap to 0.
module bitcounter_4
    import bitcounter_4_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] out_next;
    logic             wrap_next;

    // Explicit compare decides the wrap so non-power-of-2 moduli work.
    always_comb begin
        out_next  = out + WIDTH'(1);
        wrap_next = 1'b0;
        if (out == MAX_COUNT) begin
            out_next  = '0;
            wrap_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out  <= '0;
            wrap <= 1'b0;
        end else begin
            out  <= out_next;
            wrap <= wrap_next;
        end
    end

    assign tc = (out == MAX_COUNT);

endmodule : bitcounter_4

// File: tb/tb_bitcounter_4.sv
// Self-checking bench: default 4-bit counter and a mod-10 variant against an edge-count model.
module tb_bitcounter_4;

    logic       clk;
    logic       reset;
    logic [3:0] out_a;
    logic       tc_a;
    logic       wrap_a;
    logic [3:0] out_b;
    logic       tc_b;
    logic       wrap_b;

    int checks = 0;
    int passes = 0;
    int n      = 0;  // rising edges seen since last reset release

    bitcounter_4 dut_a (
        .clk  (clk),
        .reset(reset),
        .out  (out_a),
        .tc   (tc_a),
        .wrap (wrap_a)
    );

    bitcounter_4 #(
        .WIDTH    (4),
        .MAX_COUNT(4'd9)
    ) dut_b (
        .clk  (clk),
        .reset(reset),
        .out  (out_b),
        .tc   (tc_b),
        .wrap (wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) n <= 0;
        else        n <= n + 1;
    end

    function automatic int exp_out(input int m);
        return n % (m + 1);
    endfunction

    function automatic int exp_wrap(input int m);
        return (n > 0 && (n % (m + 1)) == 0) ? 1 : 0;
    endfunction

    function automatic int exp_tc(input int m);
        return (exp_out(m) == m) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model comparison every cycle, clear of clock and reset transitions.
    always @(posedge clk) begin
        #2;
        check("model out_a",  32'(out_a),  32'(exp_out(15)));
        check("model tc_a",   32'(tc_a),   32'(exp_tc(15)));
        check("model wrap_a", 32'(wrap_a), 32'(exp_wrap(15)));
        check("model out_b",  32'(out_b),  32'(exp_out(9)));
        check("model tc_b",   32'(tc_b),   32'(exp_tc(9)));
        check("model wrap_b", 32'(wrap_b), 32'(exp_wrap(9)));
        check("out_b range",  32'(out_b <= 4'd9), 32'd1);
    end

    initial begin
        bit found;
        reset = 1'b0;
        #1;
        check("por out",  32'(out_a),  32'd0);
        check("por tc",   32'(tc_a),   32'd0);
        check("por wrap", 32'(wrap_a), 32'd0);

        #9 reset = 1'b1;  // t = 10
        @(posedge clk); #1;
        check("release edge1", 32'(out_a), 32'd1);
        @(posedge clk); #1;
        check("release edge2", 32'(out_a), 32'd2);

        @(negedge clk);   // t = 30
        reset = 1'b0;
        #1;
        check("async rst out",  32'(out_a), 32'd0);
        check("async rst out_b", 32'(out_b), 32'd0);
        repeat (8) @(negedge clk);  // t = 110
        check("held rst out", 32'(out_a), 32'd0);
        reset = 1'b1;

        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 9) begin
                check("b at 9 out", 32'(out_b), 32'd9);
                check("b at 9 tc",  32'(tc_b),  32'd1);
            end
            if (k == 10) begin
                check("b wrap out",  32'(out_b),  32'd0);
                check("b wrap pulse", 32'(wrap_b), 32'd1);
            end
            if (k == 15) begin
                check("a at 15 out", 32'(out_a), 32'd15);
                check("a at 15 tc",  32'(tc_a),  32'd1);
            end
            if (k == 16) begin
                check("a wrap out",   32'(out_a),  32'd0);
                check("a wrap tc",    32'(tc_a),   32'd0);
                check("a wrap pulse", 32'(wrap_a), 32'd1);
            end
            if (k == 17) begin
                check("a post wrap out",  32'(out_a),  32'd1);
                check("a post wrap pulse", 32'(wrap_a), 32'd0);
            end
        end

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (wrap_a) found = 1'b1;
        end
        check("second wrap seen", 32'(found), 32'd1);

        #3 reset = 1'b0;
        #1;
        check("rst in pulse wrap", 32'(wrap_a), 32'd0);
        check("rst in pulse out",  32'(out_a),  32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("restart edge1", 32'(out_a), 32'd1);
        check("restart edge1 b", 32'(out_b), 32'd1);

        repeat (30) @(posedge clk);
        #4;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_bitcounter_4
